// File: rtl/uart_rx_mp.sv
// ============================================================================
//  Module   : uart_rx_mp
//  Purpose  : Oversampling UART receiver with show-ahead receive FIFO and
//             registered RTS flow control.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_mp #(
    parameter int CLK_PER_BIT = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int RTS_THRESH  = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          uart_rx,
    input  logic                          cfg_parity_en,
    input  logic                          cfg_parity_odd,
    input  logic                          cfg_stop2,
    input  logic                          rd_en,
    output logic                          rd_valid,
    output logic [7:0]                    rd_data,
    output logic                          rd_perr,
    output logic                          rd_ferr,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          rts_n
);

    localparam int c_cnt_w = $clog2(CLK_PER_BIT);
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_occ_w = c_ptr_w + 1;

    localparam logic [c_cnt_w-1:0] c_half = c_cnt_w'(CLK_PER_BIT / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(CLK_PER_BIT - 1);
    localparam logic [c_occ_w-1:0] c_depth  = c_occ_w'(FIFO_DEPTH);
    localparam logic [c_occ_w-1:0] c_thresh = c_occ_w'(RTS_THRESH);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_start  = 3'd1;
    localparam logic [2:0] c_st_data   = 3'd2;
    localparam logic [2:0] c_st_parity = 3'd3;
    localparam logic [2:0] c_st_stop1  = 3'd4;
    localparam logic [2:0] c_st_stop2  = 3'd5;
    localparam logic [2:0] c_st_break  = 3'd6;

    logic               r_rx_meta;
    logic               r_rxs;
    logic [2:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_perr;
    logic               r_ferr;
    logic               r_sh_par_en;
    logic               r_sh_par_odd;
    logic               r_sh_stop2;

    logic [9:0]         r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_occ_w-1:0] r_count;
    logic               r_overrun;
    logic               r_rts_n;

    logic w_tick;
    logic w_break;
    logic w_push;
    logic w_push_ferr;
    logic w_pop;
    logic w_full;
    logic w_accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx;
            r_rxs     <= r_rx_meta;
        end
    end

    assign w_tick  = (r_cnt == '0);
    assign w_break = (r_shift == 8'h00) && !r_rxs;

    // A frame completes at the mid-bit sample of its last stop bit; a break
    // completes at the first stop bit regardless of the two-stop setting.
    assign w_push = w_tick &&
                    (((r_state == c_st_stop1) && (!r_sh_stop2 || w_break)) ||
                     (r_state == c_st_stop2));
    assign w_push_ferr = !r_rxs || ((r_state == c_st_stop2) && r_ferr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_perr       <= 1'b0;
            r_ferr       <= 1'b0;
            r_sh_par_en  <= 1'b0;
            r_sh_par_odd <= 1'b0;
            r_sh_stop2   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (!r_rxs) begin
                        r_state <= c_st_start;
                        r_cnt   <= c_half;
                    end
                end
                c_st_start: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (r_rxs) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_sh_par_en  <= cfg_parity_en;
                        r_sh_par_odd <= cfg_parity_odd;
                        r_sh_stop2   <= cfg_stop2;
                        r_perr       <= 1'b0;
                        r_ferr       <= 1'b0;
                        r_bit_idx    <= '0;
                        r_cnt        <= c_full;
                        r_state      <= c_st_data;
                    end
                end
                c_st_data: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_shift   <= {r_rxs, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        r_cnt     <= c_full;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= r_sh_par_en ? c_st_parity : c_st_stop1;
                        end
                    end
                end
                c_st_parity: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_perr  <= r_rxs != ((^r_shift) ^ r_sh_par_odd);
                        r_cnt   <= c_full;
                        r_state <= c_st_stop1;
                    end
                end
                c_st_stop1: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_cnt <= c_full;
                        if (w_break) begin
                            r_state <= c_st_break;
                        end else if (r_sh_stop2) begin
                            r_ferr  <= !r_rxs;
                            r_state <= c_st_stop2;
                        end else begin
                            r_state <= c_st_idle;
                        end
                    end
                end
                c_st_stop2: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_state <= c_st_idle;
                    end
                end
                c_st_break: begin
                    if (r_rxs) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign w_pop    = rd_en && (r_count != '0);
    assign w_full   = (r_count == c_depth);
    assign w_accept = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= {r_shift, r_perr, w_push_ferr};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
            r_rts_n   <= 1'b1;
        end else begin
            r_overrun <= w_push && w_full && !w_pop;
            r_rts_n   <= (r_count >= c_thresh);
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_accept && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_accept && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Head fields read as zero while empty so stale entries never leak out.
    assign rd_valid   = (r_count != '0);
    assign rd_data    = rd_valid ? r_mem[r_rd_ptr][9:2] : 8'h00;
    assign rd_perr    = rd_valid && r_mem[r_rd_ptr][1];
    assign rd_ferr    = rd_valid && r_mem[r_rd_ptr][0];
    assign overrun    = r_overrun;
    assign fifo_count = r_count;
    assign rts_n      = r_rts_n;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_mp.sv
// ============================================================================
//  Module   : tb_uart_rx_mp
//  Purpose  : Scoreboard bench for uart_rx_mp (directed frames, FIFO, RTS).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_mp;

    localparam int CLK_PER_BIT = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       uart_rx = 1'b1;
    logic       cfg_parity_en = 1'b0;
    logic       cfg_parity_odd = 1'b0;
    logic       cfg_stop2 = 1'b0;
    logic       rd_en = 1'b0;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_perr;
    logic       rd_ferr;
    logic       overrun;
    logic [2:0] fifo_count;
    logic       rts_n;

    int         n_checks = 0;
    int         n_fail = 0;
    int         ovr_cnt = 0;
    logic       auto_read = 1'b0;
    logic [9:0] exp_q [$];

    uart_rx_mp #(.CLK_PER_BIT(CLK_PER_BIT), .FIFO_DEPTH(4), .RTS_THRESH(3)) dut (
        .clk(clk), .reset(reset), .uart_rx(uart_rx),
        .cfg_parity_en(cfg_parity_en), .cfg_parity_odd(cfg_parity_odd),
        .cfg_stop2(cfg_stop2), .rd_en(rd_en), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_perr(rd_perr), .rd_ferr(rd_ferr),
        .overrun(overrun), .fifo_count(fifo_count), .rts_n(rts_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic p, input logic f);
        exp_q.push_back({d, p, f});
    endtask

    task automatic bit_out(input logic v);
        uart_rx = v;
        repeat (CLK_PER_BIT) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_en, input logic par,
                              input logic s1, input logic s2_en, input logic s2);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(d[i]);
        if (par_en) bit_out(par);
        bit_out(s1);
        if (s2_en) bit_out(s2);
        uart_rx = 1'b1;
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 3000;
        while ((exp_q.size() != 0 || rd_valid) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check({name, "_drain_timeout"}, (budget == 0) ? 32'd1 : 32'd0, 32'd0);
        check({name, "_count"}, 32'(fifo_count), 32'd0);
    endtask

    // Monitor: pops the head whenever reading is enabled and compares it.
    initial begin
        logic [9:0] exp;
        forever begin
            @(negedge clk);
            rd_en = 1'b0;
            if (rd_valid && auto_read) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_entry", {22'd0, rd_data, rd_perr, rd_ferr}, 32'h3ff);
                end else begin
                    exp = exp_q.pop_front();
                    check("rx_entry", {22'd0, rd_data, rd_perr, rd_ferr}, {22'd0, exp});
                end
                rd_en = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (overrun) ovr_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (4) @(negedge clk);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_rts_n", 32'(rts_n), 32'd1);
        check("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rts_after_release", 32'(rts_n), 32'd0);
        repeat (20) @(posedge clk);

        // 8N1 0x55
        auto_read = 1'b1;
        push_exp(8'h55, 1'b0, 1'b0);
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        drain("8n1");

        // 8E1 0xA3: four ones, so correct even parity bit is 0
        cfg_parity_en = 1'b1;
        push_exp(8'hA3, 1'b0, 1'b0);
        send_frame(8'hA3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        push_exp(8'hA3, 1'b1, 1'b0);
        send_frame(8'hA3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        drain("8e1");

        // 8N2 0x0F with bad second stop
        cfg_parity_en = 1'b0;
        cfg_stop2 = 1'b1;
        push_exp(8'h0F, 1'b0, 1'b1);
        send_frame(8'h0F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (2 * CLK_PER_BIT) @(posedge clk);
        drain("8n2_ferr");

        // Break: 0x00 with stop held low for 30 bit times
        cfg_stop2 = 1'b0;
        push_exp(8'h00, 1'b0, 1'b1);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(1'b0);
        for (int i = 0; i < 30; i++) bit_out(1'b0);
        check("break_pending", 32'(exp_q.size()), 32'd0);
        check("break_count", 32'(fifo_count), 32'd0);
        uart_rx = 1'b1;
        repeat (2 * CLK_PER_BIT) @(posedge clk);
        drain("break");

        // Glitch on idle line
        uart_rx = 1'b0;
        repeat (5) @(posedge clk);
        uart_rx = 1'b1;
        repeat (40) @(posedge clk);
        check("glitch_valid", 32'(rd_valid), 32'd0);
        check("glitch_count", 32'(fifo_count), 32'd0);

        // Fill FIFO with no reads, then overrun
        auto_read = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) push_exp(8'(i), 1'b0, 1'b0);
            send_frame(8'(i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            if (i == 2) begin
                check("fill2_count", 32'(fifo_count), 32'd2);
                check("fill2_rts", 32'(rts_n), 32'd0);
            end
            if (i == 3) begin
                check("fill3_count", 32'(fifo_count), 32'd3);
                check("fill3_rts", 32'(rts_n), 32'd1);
                check("fill3_ovr", 32'(ovr_cnt), 32'd0);
            end
        end
        repeat (4) @(posedge clk);
        check("full_count", 32'(fifo_count), 32'd4);
        check("overrun_pulses", 32'(ovr_cnt), 32'd1);
        auto_read = 1'b1;
        drain("fifo_order");
        repeat (3) @(posedge clk); #1;
        check("rts_after_drain", 32'(rts_n), 32'd0);

        // Reset mid-frame with one entry already stored
        auto_read = 1'b0;
        send_frame(8'h99, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        check("pre_reset_count", 32'(fifo_count), 32'd1);
        bit_out(1'b0);
        bit_out(1'b1);
        bit_out(1'b1);
        #3;
        reset = 1'b1;
        uart_rx = 1'b1;
        #1;
        check("midreset_rts", 32'(rts_n), 32'd1);
        check("midreset_count", 32'(fifo_count), 32'd0);
        check("midreset_valid", 32'(rd_valid), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        check("post_reset_count", 32'(fifo_count), 32'd0);
        auto_read = 1'b1;
        push_exp(8'hC3, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        drain("after_reset");
        check("final_overruns", 32'(ovr_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx_mp.md
Name: uart_rx_mp

Overview:
- Oversampling UART receiver with a small receive FIFO and RTS flow control.
- Sits on the DUT side of the UART RX link: serial `uart_rx` in, `rts_n` out (matches the driver modport: the bench drives `rts_n`-side stimulus on `uart_rx` and watches `rts_n`).
- Received bytes and their error flags are presented to local logic through a show-ahead read port.

Parameters:
- CLK_PER_BIT, 16, clk cycles per UART bit (minimum 4, even).
- FIFO_DEPTH, 4, receive FIFO entries (power of 2, minimum 2).
- RTS_THRESH, 3, FIFO count at or above which `rts_n` deasserts (goes high).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- uart_rx  in  1  serial input; idle high; asynchronous to clk.
- cfg_parity_en  in  1  1 = parity bit present after data.
- cfg_parity_odd  in  1  1 = odd parity, 0 = even parity.
- cfg_stop2  in  1  1 = two stop bits checked, 0 = one.
- rd_en  in  1  pop head entry when rd_valid = 1.
- rd_valid  out  1  FIFO not empty.
- rd_data  out  8  head data byte, LSB = first received bit.
- rd_perr  out  1  head entry parity error.
- rd_ferr  out  1  head entry framing error.
- overrun  out  1  one-cycle pulse: completed frame dropped because FIFO full.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- rts_n  out  1  active-low request-to-send; 0 = ready to receive.

Behaviour:
- Clock and reset: one clock `clk`; `reset` is asynchronous and active-high.
- Reset values: FIFO empty, rd_valid=0, rd_data=0, rd_perr=0, rd_ferr=0, overrun=0, fifo_count=0, rts_n=1, FSM=IDLE, synchronizer flops=1.
- rts_n is registered. It falls to 0 on the first clk edge after reset release.
- Synchronizer: uart_rx passes through a 2-flop synchronizer. All decoding uses the synchronized value `rxs`.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK_WAIT.
- IDLE: rxs = 0 moves to START and loads a bit counter with CLK_PER_BIT/2-1.
- START: at counter expiry (mid start bit), resample.
  - rxs = 1: false start, back to IDLE, nothing pushed.
  - rxs = 0: latch cfg_* into a shadow for this frame; go to DATA with counter = CLK_PER_BIT-1.
  - cfg changes mid-frame do not affect the frame in progress.
- DATA: sample 8 bits, one per CLK_PER_BIT cycles at mid-bit, shifted LSB first. Then go to PARITY if parity is enabled, else STOP1.
- PARITY: expected bit = XOR(data) for even parity, ~XOR(data) for odd. A mismatch sets perr.
- STOP1: sample must be 1, else ferr=1. Then go to STOP2 if cfg_stop2, else complete the frame.
- STOP2: sample must be 1, else ferr=1. Then complete the frame.
- Frame completion, at the mid-bit sample of the final stop bit:
  - Push {data, perr, ferr} into the FIFO on that cycle.
  - Return to IDLE, so a start bit may be detected from the next cycle.
- Break: if data = 0x00 and the first stop sample = 0, push the entry with ferr=1 and enter BREAK_WAIT. BREAK_WAIT holds until rxs = 1, then goes to IDLE.
- FIFO full at push: frame discarded, overrun=1 for exactly one cycle, FIFO contents unchanged.
- Simultaneous push and pop with FIFO full: the pop frees a slot and the push is accepted. Count unchanged, no overrun.
- Read port:
  - Show-ahead: rd_data/rd_perr/rd_ferr reflect the head whenever rd_valid=1.
  - rd_en with rd_valid=1 pops; the next entry appears the following cycle.
  - rd_en when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Flow control: rts_n = (fifo_count >= RTS_THRESH), registered one cycle after the count change.
  - A frame already in progress is still received when rts_n rises.
- Reset mid-frame: FSM aborts to IDLE immediately; a partial frame is never pushed.

Test Plan (CLK_PER_BIT=16):
- 8N1 byte 0x55 on uart_rx → rd_valid=1 with rd_data=0x55, perr=0, ferr=0. Push occurs about 9.5 bit times (about 152 clk) plus 2 synchronizer cycles after the falling start edge.
- 8E1 byte 0xA3 with correct parity 0, then with parity bit 1 → first entry perr=0, second entry rd_data=0xA3 with perr=1.
- 8N2 byte 0x0F with second stop bit = 0 → rd_data=0x0F, ferr=1. Then a 0x00 frame with low stop held for 30 bit times → one entry 0x00 with ferr=1; no further entries until the line returns high.
- Glitch low for 5 clk on idle line → no entry pushed, FSM back in IDLE.
- Send 4 back-to-back frames 0x01..0x04 with no reads → rts_n goes 1 after the third push. A 5th frame sent with the FIFO full gives a single overrun pulse. Reads then return 0x01..0x04 in order, and rts_n returns to 0 once fifo_count < 3.
- Assert reset mid-data-bit → rts_n=1 and FIFO empty immediately. After release, a fresh 0xC3 frame is received correctly.
